// File: rtl/seq_divider8_pkg.sv
// Shared definitions for the iterative restoring divider: FSM states and default width.
package seq_divider8_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider8_sub_borrow9.sv
// Combinational N-bit subtractor: diff = a - b, borrow set when a < b.
module sub_borrow9 #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider8.sv
// Iterative unsigned restoring divider: one quotient bit per clock, START/DONE handshake.
module seq_divider8
    import seq_divider8_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_BY_ZERO
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] d, q, r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   t, diff, r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             borrow, last, accept, zero_div;
    logic             unused_msb;

    assign t = {r, q[WIDTH-1]};

    sub_borrow9 #(.N(WIDTH + 1)) u_sub (
        .a      (t),
        .b      ({1'b0, d}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign q_nx     = {q[WIDTH-2:0], ~borrow};
    assign r_nx     = borrow ? t : diff;
    // a restored partial remainder is always below the divisor, so its top bit is always 0
    assign unused_msb = r_nx[WIDTH];
    assign last     = (cnt == CW'(WIDTH - 1));
    assign accept   = START && (state == S_IDLE || state == S_FINISH);
    assign zero_div = (DIVISOR == '0);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_FINISH: begin
                if (START)
                    state_nx = zero_div ? S_FINISH : S_CALC;
                else
                    state_nx = S_IDLE;
            end
            S_CALC: begin
                if (last)
                    state_nx = S_FINISH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            d     <= '0;
            q     <= '0;
            r     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept && !zero_div) begin
                d   <= DIVISOR;
                q   <= DIVIDEND;
                r   <= '0;
                cnt <= '0;
            end else if (state == S_CALC) begin
                q   <= q_nx;
                r   <= r_nx[WIDTH-1:0];
                cnt <= cnt + 1'b1;
            end
        end
    end

    // DONE is registered from FINISH, so it trails the result load by one edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            DONE <= (state == S_FINISH);
            BUSY <= (state_nx == S_CALC);
            if (accept && zero_div) begin
                QUOTIENT    <= '1;
                REMAINDER   <= DIVIDEND;
                DIV_BY_ZERO <= 1'b1;
            end else if (accept) begin
                DIV_BY_ZERO <= 1'b0;
            end else if (state == S_CALC && last) begin
                QUOTIENT  <= q_nx;
                REMAINDER <= r_nx[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Scoreboard bench for seq_divider8: expected results queued at START, checked on each DONE.
module tb_seq_divider8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] DIVIDEND = '0;
    logic [7:0] DIVISOR = '0;
    logic [7:0] QUOTIENT, REMAINDER;
    logic       BUSY, DONE, DIV_BY_ZERO;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];

    seq_divider8 #(.WIDTH(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [7:0] dvd, input logic [7:0] dvs);
        exp_t e;
        e.dvd = dvd;
        e.dvs = dvs;
        if (dvs == 8'd0) begin
            e.q = 8'hFF;
            e.r = dvd;
            e.z = 1'b1;
        end else begin
            e.q = dvd / dvs;
            e.r = dvd % dvs;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // scoreboard: every DONE pulse must match the oldest outstanding request
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: DONE=%b with no request outstanding (Q=%0d R=%0d)",
                         DONE, QUOTIENT, REMAINDER);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({QUOTIENT, REMAINDER, DIV_BY_ZERO} !== {e.q, e.r, e.z}) begin
                    miscompares++;
                    $display("FAIL result %0d/%0d: got Q=%0d R=%0d Z=%b, expected Q=%0d R=%0d Z=%b",
                             e.dvd, e.dvs, QUOTIENT, REMAINDER, DIV_BY_ZERO, e.q, e.r, e.z);
                end
                if (!e.z) begin
                    vectors++;
                    if (({8'h00, QUOTIENT} * {8'h00, e.dvs} + {8'h00, REMAINDER}) !== {8'h00, e.dvd}
                        || REMAINDER >= e.dvs) begin
                        miscompares++;
                        $display("FAIL invariant %0d/%0d: got Q=%0d R=%0d, required Q*D+R==%0d and R<%0d",
                                 e.dvd, e.dvs, QUOTIENT, REMAINDER, e.dvd, e.dvs);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [7:0] dvd, input logic [7:0] dvs, input bit push);
        START    = 1'b1;
        DIVIDEND = dvd;
        DIVISOR  = dvs;
        if (push) sb.push_back(model(dvd, dvs));
        tick();
        START    = 1'b0;
        DIVIDEND = $urandom_range(0, 255);
        DIVISOR  = $urandom_range(0, 255);
    endtask

    // returns the negedge index at which DONE was seen (-1 on timeout) and BUSY samples before it
    task automatic wait_done(output int at, output int busy_n);
        at = -1;
        busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (BUSY === 1'b1) busy_n++;
            if (DONE === 1'b1) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d B=%b D=%b Z=%b, expected all 0",
                     QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int at, busy_n;
        do_start(8'd100, 8'd7, 1'b1);
        wait_done(at, busy_n);
        vectors++;
        if (at !== 10) begin
            miscompares++;
            $display("FAIL basic_latency: DONE at cycle %0d, expected 10 (9 edges after START)", at);
        end
        vectors++;
        if (busy_n !== 8) begin
            miscompares++;
            $display("FAIL basic_busy: BUSY high %0d cycles, expected 8", busy_n);
        end
        tick();
    endtask

    task automatic test_values();
        int at, busy_n;
        logic [7:0] tbl [3][2];
        tbl = '{'{8'd255, 8'd1}, '{8'd5, 8'd9}, '{8'd200, 8'd200}};
        for (int i = 0; i < 3; i++) begin
            do_start(tbl[i][0], tbl[i][1], 1'b1);
            wait_done(at, busy_n);
            vectors++;
            if (at !== 10) begin
                miscompares++;
                $display("FAIL values_latency %0d/%0d: DONE at %0d, expected 10", tbl[i][0], tbl[i][1], at);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int at, busy_n;
        do_start(8'd42, 8'd0, 1'b1);
        wait_done(at, busy_n);
        vectors++;
        if (at !== 2) begin
            miscompares++;
            $display("FAIL divzero_latency: DONE at %0d, expected 2", at);
        end
        vectors++;
        if (busy_n !== 0) begin
            miscompares++;
            $display("FAIL divzero_busy: BUSY high %0d cycles, expected 0", busy_n);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int at, busy_n;
        do_start(8'd100, 8'd7, 1'b1);
        repeat (3) tick();
        START    = 1'b1;
        DIVIDEND = 8'd9;
        DIVISOR  = 8'd3;
        tick();
        START    = 1'b0;
        wait_done(at, busy_n);
        vectors++;
        if (at !== 6) begin
            miscompares++;
            $display("FAIL ignored_latency: DONE at %0d, expected 6", at);
        end
        repeat (12) tick();
    endtask

    task automatic test_reset_abort();
        int at, busy_n;
        do_start(8'd100, 8'd7, 1'b0);
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        vectors++;
        if ({QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO} !== 19'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got Q=%0d R=%0d B=%b D=%b Z=%b, expected all 0",
                     QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO);
        end
        wait_done(at, busy_n);
        vectors++;
        if (at !== -1 || busy_n !== 0) begin
            miscompares++;
            $display("FAIL abort_quiet: DONE at %0d BUSY cycles %0d, expected no DONE and no BUSY", at, busy_n);
        end
        do_start(8'd50, 8'd6, 1'b1);
        wait_done(at, busy_n);
        vectors++;
        if (at !== 10) begin
            miscompares++;
            $display("FAIL abort_restart: DONE at %0d, expected 10", at);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int at, busy_n;
        do_start(8'd200, 8'd200, 1'b1);
        repeat (7) tick();
        START    = 1'b1;
        DIVIDEND = 8'd77;
        DIVISOR  = 8'd5;
        sb.push_back(model(8'd77, 8'd5));
        repeat (2) tick();
        START = 1'b0;
        wait_done(at, busy_n);
        vectors++;
        if (at !== 1) begin
            miscompares++;
            $display("FAIL b2b_first_done: DONE at %0d, expected 1", at);
        end
        wait_done(at, busy_n);
        vectors++;
        if (at !== 9) begin
            miscompares++;
            $display("FAIL b2b_second_done: DONE at %0d, expected 9", at);
        end
        tick();
    endtask

    task automatic test_random();
        int at, busy_n;
        logic [7:0] a, b;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(1, 255);
            do_start(a, b, 1'b1);
            wait_done(at, busy_n);
            if (at == -1) begin
                vectors++;
                miscompares++;
                $display("FAIL random_timeout %0d/%0d: no DONE within 40 cycles, expected at 10", a, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (3) tick();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
